mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single QSPI-backed memory controller between the instruction-fetch unit and the load/store unit. It accepts one request at a time, issues it to the memory controller as a start pulse with held operation, address and write data, and waits for the controller's completion. It returns read data and an acknowledge to the winning requester. A watchdog aborts transactions the controller never completes.

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one QSPI-backed memory controller between the instruction-fetch unit
// (if_*) and the load/store unit (ls_*). Only one transaction is in flight at
// a time. A grant is followed by a one-cycle mem_start pulse. Operation,
// address and write data are held while the controller works. The winner
// receives a one-cycle ack together with the read data. A watchdog ends any
// transaction the controller has not completed within TIMEOUT_CYCLES cycles of
// WAIT, and reports it on err.
//
// Parameters
//   DATA_BUS_WIDTH  data word width
//   ADDRESS_WIDTH   address width
//   TIMEOUT_CYCLES  maximum cycles spent in WAIT before abort (must be >= 2)
//
// Ports
//   clock, reset          system clock; asynchronous active-low reset
//   if_req/if_addr        fetch request (read only), held until if_ack
//   if_ack/if_rdata       fetch completion pulse and read data
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request, held until ls_ack
//   ls_ack/ls_rdata       load/store completion pulse and read data
//   err                   high with the ack when the transaction timed out
//   busy                  high whenever the sequencer is not idle
//   mem_start             one-cycle start pulse to the controller
//   mem_we/mem_addr/mem_wdata  operation, held from ISSUE through WAIT
//   mem_done/mem_rdata    controller completion and read data (WAIT only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_ack,
  output logic [DATA_BUS_WIDTH-1:0] if_rdata,
  input  logic                      ls_req,
  input  logic                      ls_we,
  input  logic [ADDRESS_WIDTH-1:0]  ls_addr,
  input  logic [DATA_BUS_WIDTH-1:0] ls_wdata,
  output logic                      ls_ack,
  output logic [DATA_BUS_WIDTH-1:0] ls_rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      mem_start,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic                      mem_done,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } requester_e;

  state_e                    state, state_next;
  requester_e                winner;        // owner of the transaction in flight
  requester_e                last_served;   // round-robin history for ties
  logic [CNT_W-1:0]          wait_cnt;

  // Combinational decisions consumed by the register process.
  logic                      grant;
  requester_e                grant_id;
  logic                      resp_load;     // entering RESP this cycle
  logic                      rsp_err;
  logic [DATA_BUS_WIDTH-1:0] rsp_rdata;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, independent of process order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, arbitration and response selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = REQ_IF;
    resp_load  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;

    unique case (state)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          grant      = 1'b1;
          state_next = ST_ISSUE;
          if (if_req && ls_req) begin
            // Tie: whoever was not served last goes first.
            grant_id = (last_served == REQ_LS) ? REQ_IF : REQ_LS;
          end else if (ls_req) begin
            grant_id = REQ_LS;
          end
        end
      end

      ST_ISSUE: state_next = ST_WAIT;

      ST_WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (mem_done) begin
          resp_load  = 1'b1;
          rsp_rdata  = mem_we ? '0 : mem_rdata;
          state_next = ST_RESP;
        end else if (wait_cnt == CNT_MAX) begin
          resp_load  = 1'b1;
          rsp_err    = 1'b1;
          state_next = ST_RESP;
        end
      end

      ST_RESP: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  // Outputs are computed from the next state so each one is a plain flop
  // that is valid during the cycle the state itself is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner      <= REQ_IF;
      last_served <= REQ_LS;
      wait_cnt    <= '0;
      if_ack      <= 1'b0;
      ls_ack      <= 1'b0;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      mem_start   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_start <= (state_next == ST_ISSUE);
      busy      <= (state_next != ST_IDLE);

      // The mem_* registers double as the latched request; they stay put
      // until the next grant.
      if (grant) begin
        winner      <= grant_id;
        last_served <= grant_id;
        mem_we      <= (grant_id == REQ_LS) && ls_we;
        mem_addr    <= (grant_id == REQ_LS) ? ls_addr : if_addr;
        mem_wdata   <= (grant_id == REQ_LS) ? ls_wdata : '0;
      end

      // Watchdog: cleared in ISSUE, saturates at CNT_MAX in WAIT.
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if_ack   <= resp_load && (winner == REQ_IF);
      ls_ack   <= resp_load && (winner == REQ_LS);
      if_rdata <= (resp_load && winner == REQ_IF) ? rsp_rdata : '0;
      ls_rdata <= (resp_load && winner == REQ_LS) ? rsp_rdata : '0;
      err      <= resp_load && rsp_err;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by randomized traffic for mem_arbiter. The
// controller is played cycle by cycle from the stimulus thread. Expected
// behaviour comes from a transaction-level model. The model picks the
// winner by round-robin. It computes the ack cycle from the controller
// latency and the watchdog limit, and it computes the returned data and err.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int T  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;
  logic          err;
  logic          busy;
  logic          mem_start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(
    .DATA_BUS_WIDTH (DW),
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ack    (ls_ack),
    .ls_rdata  (ls_rdata),
    .err       (err),
    .busy      (busy),
    .mem_start (mem_start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state.
  int idle_from   = 0;    // first cycle the arbiter is known to be idle
  int if_vis      = 0;    // cycle in which if_req was raised
  int ls_vis      = 0;    // cycle in which ls_req was raised
  bit ref_last_ls = 1'b1; // LS counts as served last out of reset

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({if_ack, ls_ack, if_rdata, ls_rdata, err, busy,
                mem_start, mem_we, mem_addr, mem_wdata});
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic raise(input bit do_if, input bit do_ls);
    if (do_if) begin
      if_req = 1'b1;
      if_vis = cyc;
    end
    if (do_ls) begin
      ls_req = 1'b1;
      ls_vis = cyc;
    end
  endtask

  // Idle cycles with no request pending; mem_done noise must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      mem_done  = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
      check("idle_busy", busy, 0);
      check("idle_start", mem_start, 0);
      check("idle_acks", {if_ack, ls_ack}, 0);
    end
  endtask

  // Serve the next transaction. lat is the controller latency in cycles
  // from mem_start to mem_done; lat > T means the controller never answers.
  task automatic serve_one(input int lat, input logic [DW-1:0] done_data);
    int            s, k_done, exp_ack, first_vis;
    bit            if_p, ls_p, win_ls;
    logic          exp_err, exp_we;
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_addr;
    string         rtag;

    // Arbitration happens in the first idle cycle that sees a request.
    if (if_req && ls_req) first_vis = (if_vis < ls_vis) ? if_vis : ls_vis;
    else if (if_req)      first_vis = if_vis;
    else                  first_vis = ls_vis;
    s    = (idle_from > first_vis) ? idle_from : first_vis;
    if_p = if_req && (if_vis <= s);
    ls_p = ls_req && (ls_vis <= s);
    win_ls = (if_p && ls_p) ? !ref_last_ls : ls_p;

    exp_we   = win_ls ? ls_we : 1'b0;
    exp_addr = win_ls ? ls_addr : if_addr;
    k_done   = s + 1 + lat;
    if (lat <= T) begin
      exp_ack   = k_done + 1;
      exp_err   = 1'b0;
      exp_rdata = exp_we ? '0 : done_data;
    end else begin
      exp_ack   = s + 2 + T;
      exp_err   = 1'b1;
      exp_rdata = '0;
    end
    rtag = win_ls ? "ls_rdata" : "if_rdata";

    while (cyc < exp_ack) begin
      step();
      mem_rdata = (cyc == k_done) ? done_data : DW'($urandom);
      if (cyc == k_done)                      mem_done = 1'b1;
      else if (cyc == s + 1 || cyc == exp_ack) mem_done = 1'($urandom_range(0, 1));
      else                                    mem_done = 1'b0;

      check("mem_start", mem_start, cyc == s + 1);
      check("busy", busy, (cyc > s) && (cyc <= exp_ack));
      check("if_ack", if_ack, (cyc == exp_ack) && !win_ls);
      check("ls_ack", ls_ack, (cyc == exp_ack) && win_ls);
      if (cyc > s && cyc < exp_ack) begin
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        if (win_ls) check("mem_wdata", mem_wdata, ls_wdata);
      end
      if (cyc == exp_ack) begin
        check(rtag, win_ls ? ls_rdata : if_rdata, exp_rdata);
        check("err", err, exp_err);
        if (win_ls) ls_req = 1'b0;
        else        if_req = 1'b0;
      end
    end
    idle_from   = exp_ack + 1;
    ref_last_ls = win_ls;
  endtask

  function automatic int rand_lat();
    if ($urandom_range(0, 3) == 0) return $urandom_range(T - 1, T + 3);
    return $urandom_range(1, 5);
  endfunction

  initial begin
    int start_cyc;

    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_done  = 1'b0;
    mem_rdata = '0;

    // Reset values, with both requesters already asking (tie from reset).
    step();
    check("reset_outputs", all_outs(), 0);
    if_addr  = 16'h0100;
    ls_addr  = 16'h0200;
    ls_we    = 1'b0;
    ls_wdata = 8'h11;
    raise(1'b1, 1'b1);
    step();
    check("reset_hold", all_outs(), 0);
    #3 reset = 1'b1;
    idle_from = cyc;

    // Tie round-robin: fetch, then ls; repeat the tie back-to-back.
    serve_one(2, 8'h3C);
    serve_one(3, 8'h4D);
    if_addr = 16'h0104;
    ls_addr = 16'h0208;
    raise(1'b1, 1'b1);
    serve_one(1, 8'h5E);
    serve_one(2, 8'h6F);
    idle_cycles(2);

    // Fetch read, controller answers 4 cycles after mem_start.
    if_addr = 16'h0010;
    raise(1'b1, 1'b0);
    serve_one(4, 8'hA5);
    idle_cycles(2);

    // Load/store write.
    ls_we    = 1'b1;
    ls_addr  = 16'h1234;
    ls_wdata = 8'h5C;
    raise(1'b0, 1'b1);
    serve_one(3, 8'hEE);
    idle_cycles(1);

    // Timeout, then a normal transaction right behind it.
    if_addr = 16'h0777;
    raise(1'b1, 1'b0);
    serve_one(100, 8'h00);
    if_addr = 16'h0778;
    raise(1'b1, 1'b0);
    serve_one(3, 8'h96);
    idle_cycles(1);

    // mem_done on the final watchdog cycle: completion wins.
    ls_we   = 1'b0;
    ls_addr = 16'h4321;
    raise(1'b0, 1'b1);
    serve_one(T, 8'hC3);
    idle_cycles(1);

    // Reset two cycles after mem_start.
    if_addr = 16'h0010;
    raise(1'b1, 1'b0);
    start_cyc = cyc;
    mem_done  = 1'b0;
    step();
    check("abort_start", mem_start, 1);
    check("abort_addr", mem_addr, 16'h0010);
    step();
    step();
    check("abort_busy", busy, 1);
    #2 reset = 1'b0;
    if_req = 1'b0;
    #1 check("abort_outputs", all_outs(), 0);
    step();
    check("abort_no_ack", {if_ack, ls_ack, busy}, 0);
    step();
    check("abort_no_ack", {if_ack, ls_ack, busy}, 0);
    check("abort_elapsed", cyc - start_cyc, 5);
    #3 reset = 1'b1;
    idle_from   = cyc;
    ref_last_ls = 1'b1;
    if_addr = 16'h0010;
    raise(1'b1, 1'b0);
    serve_one(4, 8'hA5);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int pat;
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      pat      = $urandom_range(1, 3);
      if_addr  = AW'($urandom);
      ls_addr  = AW'($urandom);
      ls_we    = 1'($urandom_range(0, 1));
      ls_wdata = DW'($urandom);
      raise(pat[0], pat[1]);
      while (if_req || ls_req) serve_one(rand_lat(), DW'($urandom));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
